color_filter: RTL and testbench
===============================

Name: color_filter

Overview:
- Sits between the I2C controller and the colour-valid outputs.
- Takes raw 24-bit R/G/B sensor readings, each qualified by a one-cycle strobe.
- Block-averages 2^AVG_SHIFT readings, classifies the average by channel dominance, and debounces the result before driving one-hot colour outputs.
- Purpose: replaces per-cycle raw comparison with stable, noise-filtered colour decisions.

Parameters:
- AVG_SHIFT, 2: log2 of samples per average block (1..6).
- STABLE_CNT, 3: consecutive identical classifications required before outputs change (1..15).
- DARK_THR, 26'd300: minimum avg_r+avg_g+avg_b for a valid colour; used only with COLOR_FILT_DARK_EN.

Ports:
- i2c_clk  in  1  clock
- sys_rst_n  in  1  asynchronous, active-low reset
- data_vld  in  1  one-cycle strobe; data_r/g/b hold a new reading
- data_r  in  24  raw red reading
- data_g  in  24  raw green reading
- data_b  in  24  raw blue reading
- r_valid  out  1  debounced red dominant
- g_valid  out  1  debounced green dominant
- b_valid  out  1  debounced blue dominant
- color_code  out  2  0=none, 1=red, 2=green, 3=blue; mirrors the one-hot outputs
- color_chg  out  1  one-cycle pulse when the outputs change
- avg_r, avg_g, avg_b  out  24 each  last completed block average

Behaviour:
- Reset (asynchronous): all outputs 0, accumulators 0, sample counter 0, candidate 0, stable counter 0, FSM in S_ACC.
- FSM states and transitions:
  - S_ACC: on data_vld, add each channel into a (24+AVG_SHIFT)-bit accumulator and increment the sample counter. When the counter reaches 2^AVG_SHIFT-1 with data_vld, go to S_AVG.
  - S_AVG, 1 cycle: avg_x <= acc_x >> AVG_SHIFT (truncation); clear accumulators and sample counter; go to S_CLS.
  - S_CLS, 1 cycle: compute class from the avg registers:
    - red if avg_r > avg_g+avg_b;
    - else green if avg_g > avg_r+avg_b;
    - else blue if avg_b > avg_r+avg_g;
    - else none.
    - Sums are 25-bit, no overflow. Comparisons are strict; ties give none. Go to S_UPD.
  - S_UPD, 1 cycle:
    - If class == candidate, stable counter increments, saturating at STABLE_CNT. Otherwise candidate <= class and stable counter <= 1.
    - If the new counter value == STABLE_CNT and candidate differs from the current color_code: update r/g/b_valid and color_code, pulse color_chg for 1 cycle.
    - Go to S_ACC.
- Latency: outputs update 3 cycles after the strobe that completes the block; color_chg is asserted on that same cycle.
- data_vld while not in S_ACC: sample dropped, no error flag. The source must space strobes at least 4 cycles apart, which I2C read timing always satisfies.
- STABLE_CNT=1: outputs follow every block classification.
- Exactly one of r/g/b_valid is high, or none. color_code always consistent with them.
- Reset mid-block: partial accumulation discarded; the first post-reset block starts at the next strobe.

Optional Feature:
- COLOR_FILT_DARK_EN defined: in S_CLS, if avg_r+avg_g+avg_b (26-bit) < DARK_THR, class is forced to none regardless of dominance.
- Undefined: no brightness check, and DARK_THR is unused.

Decomposition:
- Shared package color_pkg holds:
  - color_code encodings COLOR_NONE/RED/GREEN/BLUE;
  - FSM state encodings S_ACC/S_AVG/S_CLS/S_UPD;
  - one-hot-from-code helper.
- One sub-module: color_debounce (candidate/stable counter/output registers, S_UPD logic).
- Averaging FSM stays in color_filter.

Test Plan:
- AVG_SHIFT=2, STABLE_CNT=3. Send 12 strobes of r=1000, g=100, b=100 → after strobe 12, plus 3 cycles: r_valid=1, color_code=1, color_chg pulses once. avg_r=1000, avg_g=100, avg_b=100.
- Averaging: 4 strobes r=1,2,3,5, g=b=0 → avg_r=2 (11>>2, truncation).
- Debounce: 2 red blocks then 1 green block then 3 green blocks → no red output ever; g_valid=1 only after the 3rd consecutive green block; single color_chg.
- Tie/none: blocks with r=200, g=100, b=100 (equal, not greater) → class none. After 3 such blocks, outputs go to all-zero with color_chg pulse if previously red.
- Reset asserted after 2 of 4 strobes, then released, then 4 strobes of blue-dominant data → avg from only the post-reset 4 samples. Outputs 0 until 3 blue blocks complete.
- With COLOR_FILT_DARK_EN and DARK_THR=300: blocks r=100, g=10, b=10 → class none (sum 120 < 300). Without the macro, the same data gives red after 3 blocks.

Source files
------------

// File: rtl/color_pkg.sv
// color_pkg: shared colour codes, averaging FSM states and one-hot helper
package color_pkg;
    typedef enum logic [1:0] {
        COLOR_NONE  = 2'd0,
        COLOR_RED   = 2'd1,
        COLOR_GREEN = 2'd2,
        COLOR_BLUE  = 2'd3
    } color_t;
    typedef enum logic [1:0] {S_ACC, S_AVG, S_CLS, S_UPD} state_t;
    // returned as {b, g, r}
    function automatic logic [2:0] code2onehot(color_t c);
        return c == COLOR_RED ? 3'b001 : c == COLOR_GREEN ? 3'b010 : c == COLOR_BLUE ? 3'b100 : 3'b000;
    endfunction
endpackage

// File: rtl/color_filter_if.sv
// color_filter_if: raw reading strobe in, debounced colour decision and block averages out
interface color_filter_if;
    logic        data_vld;
    logic [23:0] data_r, data_g, data_b;
    logic        r_valid, g_valid, b_valid;
    logic [1:0]  color_code;
    logic        color_chg;
    logic [23:0] avg_r, avg_g, avg_b;
    modport master (
        output data_vld, data_r, data_g, data_b,
        input  r_valid, g_valid, b_valid, color_code, color_chg, avg_r, avg_g, avg_b
    );
    modport slave (
        input  data_vld, data_r, data_g, data_b,
        output r_valid, g_valid, b_valid, color_code, color_chg, avg_r, avg_g, avg_b
    );
endinterface

// File: rtl/color_debounce.sv
// color_debounce: needs STABLE_CNT identical block classes in a row before moving the one-hot outputs
module color_debounce
    import color_pkg::*;
#(
    parameter int STABLE_CNT = 3
) (
    input  logic       i2c_clk,
    input  logic       sys_rst_n,
    input  logic       upd,
    input  color_t     cls,
    output logic       r_valid,
    output logic       g_valid,
    output logic       b_valid,
    output logic [1:0] color_code,
    output logic       color_chg
);
    color_t     cand;
    logic [3:0] stab, stab_n;

    assign stab_n = cls != cand ? 4'd1 : stab == 4'(STABLE_CNT) ? stab : stab + 4'd1;

    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cand                        <= COLOR_NONE;
            stab                        <= '0;
            {b_valid, g_valid, r_valid} <= '0;
            color_code                  <= '0;
            color_chg                   <= 1'b0;
        end else begin
            color_chg <= 1'b0;
            if (upd) begin
                cand <= cls;
                stab <= stab_n;
                if (stab_n == 4'(STABLE_CNT) && cls != color_code) begin
                    {b_valid, g_valid, r_valid} <= code2onehot(cls);
                    color_code                  <= cls;
                    color_chg                   <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/color_filter.sv
// color_filter: block-averages R/G/B readings, classifies channel dominance, debounces the colour outputs.
// Define COLOR_FILT_DARK_EN to force averages whose channel sum is below DARK_THR to no colour.
module color_filter
    import color_pkg::*;
#(
    parameter int          AVG_SHIFT  = 2,
    parameter int          STABLE_CNT = 3,
    parameter logic [25:0] DARK_THR   = 26'd300
) (
    input logic           i2c_clk,
    input logic           sys_rst_n,
    color_filter_if.slave bus
);
    localparam int AW = 24 + AVG_SHIFT;

    state_t               state;
    logic [AW-1:0]        acc_r, acc_g, acc_b;
    logic [AVG_SHIFT-1:0] cnt;
    logic [23:0]          avg_r, avg_g, avg_b;
    color_t               cls, cls_d, dom;

    assign dom = {1'b0, avg_r} > {1'b0, avg_g} + {1'b0, avg_b} ? COLOR_RED   :
                 {1'b0, avg_g} > {1'b0, avg_r} + {1'b0, avg_b} ? COLOR_GREEN :
                 {1'b0, avg_b} > {1'b0, avg_r} + {1'b0, avg_g} ? COLOR_BLUE  : COLOR_NONE;
`ifdef COLOR_FILT_DARK_EN
    logic [25:0] bright;
    assign bright = {2'b0, avg_r} + {2'b0, avg_g} + {2'b0, avg_b};
    assign cls_d  = bright < DARK_THR ? COLOR_NONE : dom;
`else
    logic unused_dark;
    assign unused_dark = ^DARK_THR;
    assign cls_d       = dom;
`endif

    always_ff @(posedge i2c_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state                 <= S_ACC;
            {acc_r, acc_g, acc_b} <= '0;
            cnt                   <= '0;
            {avg_r, avg_g, avg_b} <= '0;
            cls                   <= COLOR_NONE;
        end else begin
            case (state)
                S_ACC: if (bus.data_vld) begin
                    acc_r <= acc_r + AW'(bus.data_r);
                    acc_g <= acc_g + AW'(bus.data_g);
                    acc_b <= acc_b + AW'(bus.data_b);
                    cnt   <= cnt + AVG_SHIFT'(1);
                    if (&cnt) state <= S_AVG;
                end
                S_AVG: begin
                    avg_r                 <= acc_r[AW-1:AVG_SHIFT];
                    avg_g                 <= acc_g[AW-1:AVG_SHIFT];
                    avg_b                 <= acc_b[AW-1:AVG_SHIFT];
                    {acc_r, acc_g, acc_b} <= '0;
                    cnt                   <= '0;
                    state                 <= S_CLS;
                end
                S_CLS: begin
                    cls   <= cls_d;
                    state <= S_UPD;
                end
                default: state <= S_ACC;
            endcase
        end
    end

    assign bus.avg_r = avg_r;
    assign bus.avg_g = avg_g;
    assign bus.avg_b = avg_b;

    color_debounce #(.STABLE_CNT(STABLE_CNT)) u_debounce (
        .i2c_clk    (i2c_clk),
        .sys_rst_n  (sys_rst_n),
        .upd        (state == S_UPD),
        .cls        (cls),
        .r_valid    (bus.r_valid),
        .g_valid    (bus.g_valid),
        .b_valid    (bus.b_valid),
        .color_code (bus.color_code),
        .color_chg  (bus.color_chg)
    );
endmodule

// File: tb/tb_color_filter.sv
// tb_color_filter: random and directed readings against a block-average / run-length reference model
module tb_color_filter;
    localparam int          AVG_SHIFT  = 2;
    localparam int          STABLE_CNT = 3;
    localparam int          NS         = 1 << AVG_SHIFT;
    localparam logic [25:0] DARK_THR   = 26'd300;

    logic i2c_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    color_filter_if bus();

    color_filter #(.AVG_SHIFT(AVG_SHIFT), .STABLE_CNT(STABLE_CNT), .DARK_THR(DARK_THR)) dut (
        .i2c_clk   (i2c_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    always #5 i2c_clk = ~i2c_clk;

    int tests = 0, fails = 0;
    int q_r[$], q_g[$], q_b[$];
    int hist[$];
    int exp_code = 0;
    int exp_r = 0, exp_g = 0, exp_b = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int classify(input int r, input int g, input int b);
`ifdef COLOR_FILT_DARK_EN
        if (r + g + b < int'(DARK_THR)) return 0;
`endif
        if (r > g + b) return 1;
        if (g > r + b) return 2;
        if (b > r + g) return 3;
        return 0;
    endfunction

    task automatic check_out(input string tag, input int chg);
        int oh;
        oh = exp_code == 0 ? 0 : 1 << (exp_code - 1);
        check({tag, ".avg_r"}, 32'(bus.avg_r), exp_r);
        check({tag, ".avg_g"}, 32'(bus.avg_g), exp_g);
        check({tag, ".avg_b"}, 32'(bus.avg_b), exp_b);
        check({tag, ".code"}, 32'(bus.color_code), exp_code);
        check({tag, ".onehot"}, 32'({bus.b_valid, bus.g_valid, bus.r_valid}), oh);
        check({tag, ".chg"}, 32'(bus.color_chg), chg);
    endtask

    task automatic do_reset();
        @(negedge i2c_clk);
        sys_rst_n = 1'b0;
        q_r.delete(); q_g.delete(); q_b.delete(); hist.delete();
        exp_code = 0; exp_r = 0; exp_g = 0; exp_b = 0;
        @(negedge i2c_clk);
        sys_rst_n = 1'b1;
        check_out("reset", 0);
    endtask

    // one strobe, then 3 idle cycles: a block's outputs are visible on return
    task automatic send(input string tag, input int r, input int g, input int b);
        int sr, sg, sb, c, run, chg;
        @(negedge i2c_clk);
        bus.data_vld = 1'b1;
        bus.data_r = 24'(r); bus.data_g = 24'(g); bus.data_b = 24'(b);
        @(negedge i2c_clk);
        bus.data_vld = 1'b0;
        repeat (3) @(negedge i2c_clk);
        q_r.push_back(r); q_g.push_back(g); q_b.push_back(b);
        if (q_r.size() < NS) begin
            check({tag, ".midchg"}, 32'(bus.color_chg), 0);
            return;
        end
        sr = 0; sg = 0; sb = 0;
        for (int i = 0; i < NS; i++) begin
            sr += q_r[i]; sg += q_g[i]; sb += q_b[i];
        end
        q_r.delete(); q_g.delete(); q_b.delete();
        exp_r = sr / NS; exp_g = sg / NS; exp_b = sb / NS;
        c = classify(exp_r, exp_g, exp_b);
        hist.push_back(c);
        run = 0;
        for (int i = hist.size() - 1; i >= 0 && hist[i] == c; i--) run++;
        chg = (run >= STABLE_CNT && c != exp_code) ? 1 : 0;
        if (chg != 0) exp_code = c;
        check_out(tag, chg);
    endtask

    task automatic block(input string tag, input int r, input int g, input int b);
        for (int i = 0; i < NS; i++) send(tag, r, g, b);
    endtask

    initial begin
        int kind, hi, lo, r, g, b;
        bus.data_vld = 1'b0;
        bus.data_r = '0; bus.data_g = '0; bus.data_b = '0;
        repeat (2) @(negedge i2c_clk);
        sys_rst_n = 1'b1;
        check_out("por", 0);

        for (int i = 0; i < 3; i++) block("red", 1000, 100, 100);
        check("red.r_valid", 32'(bus.r_valid), 1);

        send("trunc", 1, 0, 0); send("trunc", 2, 0, 0); send("trunc", 3, 0, 0); send("trunc", 5, 0, 0);
        check("trunc.avg_r", 32'(bus.avg_r), 2);

        do_reset();
        block("deb", 1000, 100, 100); block("deb", 1000, 100, 100);
        for (int i = 0; i < 4; i++) block("deb", 100, 1000, 100);
        check("deb.g_valid", 32'(bus.g_valid), 1);

        do_reset();
        for (int i = 0; i < 3; i++) block("tie_pre", 1000, 100, 100);
        for (int i = 0; i < 3; i++) block("tie", 200, 100, 100);
        check("tie.code", 32'(bus.color_code), 0);

        do_reset();
        send("rst_mid", 5000, 0, 0); send("rst_mid", 5000, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) block("blue", 50, 50, 900);
        check("blue.b_valid", 32'(bus.b_valid), 1);

        do_reset();
        for (int i = 0; i < 3; i++) block("dark", 100, 10, 10);
        block("wide_tie", 24'hFFFFFF, 24'hFFFFFF, 0);
        for (int i = 0; i < 3; i++) block("wide_red", 24'hFFFFFF, 24'h7FFFFF, 24'h7FFFFF);

        kind = 0;
        for (int blk = 0; blk < 60; blk++) begin
            if ($urandom_range(0, 2) == 0) kind = int'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) begin
                send("rnd_part", int'($urandom_range(0, 24'hFFFFFF)), 0, 0);
                do_reset();
            end
            hi = 24'hFFFFFF;
            lo = kind == 4 ? hi : 24'h3FFFFF;
            for (int s = 0; s < NS; s++) begin
                r = int'($urandom_range(0, kind == 0 ? hi : lo));
                g = int'($urandom_range(0, kind == 1 ? hi : lo));
                b = int'($urandom_range(0, kind == 2 ? hi : lo));
                send("rnd", r, g, b);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
